// File: rtl/flasher_arbiter.sv
// Round-robin arbiter sharing one boundFlasher among N_REQ requesters.
// Optional macro FLASHER_ARB_KICKBACK_EN forwards the owner's req to flick during RUN.
module flasher_arbiter #(
    parameter int N_REQ          = 4,
    parameter int FLICK_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [15:0]      lamps,
    output logic             flick,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int FW = $clog2(FLICK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PTR_RST    = PW'(N_REQ - 1);
    localparam logic [FW-1:0] FLICK_LAST = FW'(FLICK_CYCLES);
    localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIME_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, FLICK, RUN} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt, winner;
    logic [FW-1:0]    pcnt, pcnt_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             seen_nz, seen_nz_nxt;
    logic             flick_nxt, done_nxt, timeout_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic             start, finish, expire, ending, found;

    assign start  = (req != '0) && (lamps == 16'h0000);
    assign finish = seen_nz && (lamps == 16'h0000);
    assign expire = (tcnt == TIME_LAST);
    // The done/timeout pulse cycle is the last cycle of a run; grant drops after it.
    assign ending = done | timeout;
    assign busy   = (state != IDLE);

    // First requesting bit above the last winner, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= PTR_RST;
            grant   <= '0;
            flick   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            seen_nz <= 1'b0;
            pcnt    <= '0;
            tcnt    <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            grant   <= grant_nxt;
            flick   <= flick_nxt;
            done    <= done_nxt;
            timeout <= timeout_nxt;
            seen_nz <= seen_nz_nxt;
            pcnt    <= pcnt_nxt;
            tcnt    <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FLICK;
            FLICK:   if (pcnt == FLICK_LAST) state_nxt = RUN;
            RUN:     if (ending) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt     = ptr;
        grant_nxt   = grant;
        flick_nxt   = 1'b0;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        seen_nz_nxt = seen_nz;
        pcnt_nxt    = pcnt;
        tcnt_nxt    = tcnt;
        case (state)
            IDLE: begin
                grant_nxt   = '0;
                seen_nz_nxt = 1'b0;
                if (start) begin
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                    ptr_nxt           = winner;
                    flick_nxt         = 1'b1;
                    pcnt_nxt          = FW'(1);
                    tcnt_nxt          = '0;
                end
            end
            FLICK: begin
                if (lamps != 16'h0000) seen_nz_nxt = 1'b1;
                if (pcnt != FLICK_LAST) begin
                    pcnt_nxt  = pcnt + FW'(1);
                    flick_nxt = 1'b1;
                end
            end
            RUN: begin
                if (ending) begin
                    grant_nxt   = '0;
                    seen_nz_nxt = 1'b0;
                end else begin
                    if (lamps != 16'h0000) seen_nz_nxt = 1'b1;
                    // A normal finish takes priority over a timeout in the same cycle.
                    if (finish) done_nxt = 1'b1;
                    else if (expire) timeout_nxt = 1'b1;
                    if (tcnt != TIME_MAX) tcnt_nxt = tcnt + TW'(1);
`ifdef FLASHER_ARB_KICKBACK_EN
                    flick_nxt = req[ptr];
`else
                    flick_nxt = 1'b0;
`endif
                end
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_flasher_arbiter.sv
// Scoreboard bench for flasher_arbiter: expected grants and end events are queued
// when stimulus is driven and popped when the arbiter produces them.
module tb_flasher_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] lamps;
    logic        flick;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_grant_q[$];
    logic [1:0] exp_event_q[$];   // {done,timeout}

    logic       ok;
    int         n;
    logic [3:0] want_g;
    logic [1:0] want_e;
    logic       want_f;

    always #5 clk = ~clk;

    flasher_arbiter #(
        .N_REQ(4),
        .FLICK_CYCLES(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .lamps(lamps),
        .flick(flick),
        .grant(grant),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    task tick();
        @(negedge clk);
    endtask

    task applyStimulus(input logic [3:0] r, input logic [15:0] l);
        req   = r;
        lamps = l;
    endtask

    task wait_grant(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (grant != 4'b0000) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task wait_end(output logic got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || timeout) begin
                got = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task test_reset();
        rst = 1'b1;
        applyStimulus(4'b1111, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({flick, grant, busy, done, timeout} !== 8'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: flick=%b grant=%b busy=%b done=%b timeout=%b expected all zero",
                         flick, grant, busy, done, timeout);
            end
        end
        rst = 1'b0;
        applyStimulus(4'b0000, 16'h0000);
        tick();
    endtask

    task test_fairness();
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) exp_grant_q.push_back(order[k]);
        applyStimulus(4'b1111, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            wait_grant(ok);
            want_g = exp_grant_q.pop_front();
            checks++;
            if (!ok || grant !== want_g) begin
                errors++;
                $display("[TB] FAIL fairness_grant[%0d]: grant=%b expected=%b", k, grant, want_g);
            end
            applyStimulus(4'b1111, 16'h003F);
            repeat (4) tick();
            exp_event_q.push_back(2'b10);
            lamps = 16'h0000;
            wait_end(ok, n);
            want_e = exp_event_q.pop_front();
            checks++;
            if (!ok || {done, timeout} !== want_e || grant !== order[k]) begin
                errors++;
                $display("[TB] FAIL fairness_done[%0d]: done,timeout=%b grant=%b expected %b with grant %b",
                         k, {done, timeout}, grant, want_e, order[k]);
            end
            lamps = 16'h0012;
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++;
                if (grant !== 4'b0000 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_lamps_block: grant=%b busy=%b expected 0000 and 0", grant, busy);
                end
            end
            if (k == 4) req = 4'b0000;
            lamps = 16'h0000;
        end
        tick();
    endtask

    task test_single_run();
        exp_grant_q.push_back(4'b0100);
        applyStimulus(4'b0100, 16'h0000);
        tick();
        want_g = exp_grant_q.pop_front();
        checks++;
        if (grant !== want_g || flick !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency: grant=%b flick=%b busy=%b expected %b 1 1", grant, flick, busy, want_g);
        end
        applyStimulus(4'b0000, 16'h003F);
        tick();
        checks++;
        if (flick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_flick_2: flick=%b expected 1", flick);
        end
        tick();
        checks++;
        if (flick !== 1'b0 || grant !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_flick_end: flick=%b grant=%b expected 0 0100", flick, grant);
        end
        repeat (8) tick();
        exp_event_q.push_back(2'b10);
        lamps = 16'h0000;
        wait_end(ok, n);
        want_e = exp_event_q.pop_front();
        checks++;
        if (!ok || {done, timeout} !== want_e || grant !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_done: done,timeout=%b grant=%b expected %b 0100", {done, timeout}, grant, want_e);
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: grant=%b done=%b busy=%b expected 0000 0 0", grant, done, busy);
        end
    endtask

    task test_kickback();
        exp_grant_q.push_back(4'b0001);
        applyStimulus(4'b0001, 16'h0000);
        wait_grant(ok);
        want_g = exp_grant_q.pop_front();
        checks++;
        if (!ok || grant !== want_g) begin
            errors++;
            $display("[TB] FAIL kick_grant: grant=%b expected=%b", grant, want_g);
        end
        applyStimulus(4'b0000, 16'h003F);
        repeat (2) tick();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) req = 4'b1000;
`ifdef FLASHER_ARB_KICKBACK_EN
            want_f = (i == 0);
`else
            want_f = 1'b0;
`endif
            checks++;
            if (flick !== want_f || grant !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL kick_flick[%0d]: flick=%b grant=%b expected %b 0001", i, flick, grant, want_f);
            end
        end
        exp_grant_q.push_back(4'b1000);
        exp_event_q.push_back(2'b10);
        lamps = 16'h0000;
        wait_end(ok, n);
        want_e = exp_event_q.pop_front();
        checks++;
        if (!ok || {done, timeout} !== want_e) begin
            errors++;
            $display("[TB] FAIL kick_done: done,timeout=%b expected %b", {done, timeout}, want_e);
        end
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL kick_release: grant=%b expected 0000", grant);
        end
        wait_grant(ok);
        want_g = exp_grant_q.pop_front();
        checks++;
        if (!ok || grant !== want_g) begin
            errors++;
            $display("[TB] FAIL kick_queued_grant: grant=%b expected=%b", grant, want_g);
        end
        applyStimulus(4'b0000, 16'h003F);
        repeat (4) tick();
        exp_event_q.push_back(2'b10);
        lamps = 16'h0000;
        wait_end(ok, n);
        want_e = exp_event_q.pop_front();
        checks++;
        if (!ok || {done, timeout} !== want_e || grant !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL kick_queued_done: done,timeout=%b grant=%b expected %b 1000", {done, timeout}, grant, want_e);
        end
        tick();
    endtask

    task test_timeout();
        exp_grant_q.push_back(4'b0001);
        exp_event_q.push_back(2'b01);
        applyStimulus(4'b0011, 16'h0000);
        wait_grant(ok);
        want_g = exp_grant_q.pop_front();
        checks++;
        if (!ok || grant !== want_g) begin
            errors++;
            $display("[TB] FAIL timeout_grant: grant=%b expected=%b", grant, want_g);
        end
        applyStimulus(4'b0010, 16'h0000);
        repeat (2) tick();
        wait_end(ok, n);
        want_e = exp_event_q.pop_front();
        checks++;
        if (!ok || {done, timeout} !== want_e || grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL timeout_event: done,timeout=%b grant=%b expected %b 0001", {done, timeout}, grant, want_e);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL timeout_latency: cycles=%0d expected 16", n);
        end
        exp_grant_q.push_back(4'b0010);
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_release: grant=%b busy=%b timeout=%b expected 0000 0 0", grant, busy, timeout);
        end
        tick();
        want_g = exp_grant_q.pop_front();
        checks++;
        if (grant !== want_g) begin
            errors++;
            $display("[TB] FAIL back_to_back_grant: grant=%b expected=%b", grant, want_g);
        end
        applyStimulus(4'b0000, 16'h003F);
        repeat (4) tick();
        exp_event_q.push_back(2'b10);
        lamps = 16'h0000;
        wait_end(ok, n);
        want_e = exp_event_q.pop_front();
        checks++;
        if (!ok || {done, timeout} !== want_e) begin
            errors++;
            $display("[TB] FAIL back_to_back_done: done,timeout=%b expected %b", {done, timeout}, want_e);
        end
        tick();
    endtask

    task test_mid_run_reset();
        applyStimulus(4'b0100, 16'h0000);
        wait_grant(ok);
        checks++;
        if (!ok || flick !== 1'b1 || grant !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midreset_setup: flick=%b grant=%b expected 1 0100", flick, grant);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (flick !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_flick: flick=%b grant=%b busy=%b expected 0 0000 0", flick, grant, busy);
        end
        tick();
        rst = 1'b0;
        exp_grant_q.push_back(4'b0001);
        applyStimulus(4'b1111, 16'h0000);
        wait_grant(ok);
        want_g = exp_grant_q.pop_front();
        checks++;
        if (!ok || grant !== want_g) begin
            errors++;
            $display("[TB] FAIL reset_winner_first: grant=%b expected=%b", grant, want_g);
        end
        repeat (2) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (flick !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_run: flick=%b grant=%b busy=%b expected 0 0000 0", flick, grant, busy);
        end
        tick();
        rst = 1'b0;
        exp_grant_q.push_back(4'b0001);
        wait_grant(ok);
        want_g = exp_grant_q.pop_front();
        checks++;
        if (!ok || grant !== want_g) begin
            errors++;
            $display("[TB] FAIL reset_winner_again: grant=%b expected=%b", grant, want_g);
        end
        rst = 1'b1;
        applyStimulus(4'b0000, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'b1111, 16'h0000);
        $display("[TB] starting flasher_arbiter bench");
        test_reset();
        test_fairness();
        test_single_run();
        test_kickback();
        test_timeout();
        test_mid_run_reset();
        checks++;
        if (exp_grant_q.size() != 0 || exp_event_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: grants left=%0d events left=%0d expected 0 0",
                     exp_grant_q.size(), exp_event_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
